line_buffer_ctrl: RTL and testbench



---
 rtl/line_buffer_ctrl_pkg.sv | 15 +
 rtl/line_buffer_ctrl.sv | 169 ++++++++++++++++
 tb/tb_line_buffer_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/line_buffer_ctrl_pkg.sv
// Shared definitions for the 3-row line-buffer controller.
// No logic here: only the FSM state encoding and dimension limits.
// Backpressure: not applicable.
package line_buffer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // Smallest image side that still yields a 3x3 window.
  localparam int MIN_DIM = 3;

endpackage

// File: rtl/line_buffer_ctrl.sv
// Line-buffer controller: raster pixel intake, wen/ren strobes, 3x3 window announce, drain.
// Latency: wen/ren same cycle as the pixel handshake; m_valid one cycle after the completing pixel.
// Backpressure: a pending unconsumed window stalls s_ready/wen/ren so the buffer outputs freeze.
module line_buffer_ctrl
  import line_buffer_ctrl_pkg::*;
#(
  parameter int ADDR_BIT = 3,
  parameter int ROW_BIT  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_BIT:0]   width,
  input  logic [ROW_BIT-1:0]  height,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [2:0]          empty,
  input  logic [2:0]          almost_full,
  output logic                wen,
  output logic                ren,
  output logic [ADDR_BIT:0]   depth,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [ROW_BIT-1:0]  win_row,
  output logic [ADDR_BIT:0]   win_col,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int CW = ADDR_BIT + 1;
  localparam int PW = ADDR_BIT + ROW_BIT;

  localparam logic [CW-1:0]      MIN_W = CW'(MIN_DIM);
  localparam logic [CW-1:0]      MAX_W = CW'(1) << ADDR_BIT;
  localparam logic [ROW_BIT-1:0] MIN_H = ROW_BIT'(MIN_DIM);

  state_e               state_q, state_d;
  logic [CW-1:0]        w_q, w_d;
  logic [ROW_BIT-1:0]   h_q, h_d;
  logic [CW-1:0]        col_q, col_d;
  logic [ROW_BIT-1:0]   row_q, row_d;
  logic [PW-1:0]        prime_q, prime_d;
  logic                 last_q, last_d;
  logic                 m_valid_q, m_valid_d;
  logic [ROW_BIT-1:0]   win_row_q, win_row_d;
  logic [CW-1:0]        win_col_q, win_col_d;
  logic                 err_q, err_d;

  logic [PW-1:0]        prime_tgt;
  logic                 primed, hold, acc, drained, col_end, row_end;
  logic                 unused_af;

  // Only row 0 almost-full guards writes; upper rows are fed by the buffer itself.
  assign unused_af = ^almost_full[2:1];

  // Handshake, strobes and status derived from current state.
  always_comb begin
    prime_tgt = (PW'(w_q) << 1) + PW'(2);
    primed    = (prime_q == prime_tgt);
    hold      = m_valid_q & ~m_ready;
    drained   = (empty == 3'b111);
    s_ready   = (state_q == ST_RUN) & ~hold & ~last_q;
    acc       = s_valid & s_ready;
    wen       = acc;
    ren       = (acc & primed) | ((state_q == ST_FLUSH) & ~drained);
    done      = (state_q == ST_FLUSH) & drained;
    busy      = (state_q == ST_RUN) | ((state_q == ST_FLUSH) & ~drained);
    col_end   = (col_q == w_q - CW'(1));
    row_end   = (row_q == h_q - ROW_BIT'(1));
  end

  // Next-state: frame setup, position counters, window announce, error flag.
  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    col_d     = col_q;
    row_d     = row_q;
    prime_d   = prime_q;
    last_d    = last_q;
    m_valid_d = m_valid_q;
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (width >= MIN_W && width <= MAX_W && height >= MIN_H) begin
            state_d   = ST_RUN;
            w_d       = width;
            h_d       = height;
            col_d     = '0;
            row_d     = '0;
            prime_d   = '0;
            last_d    = 1'b0;
            m_valid_d = 1'b0;
            err_d     = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (m_valid_q & m_ready) begin
          m_valid_d = 1'b0;
          // The last pixel always completes a window; its consumption ends intake.
          if (last_q) state_d = ST_FLUSH;
        end
        if (acc) begin
          if (!primed) prime_d = prime_q + PW'(1);
          if (row_q >= ROW_BIT'(2) && col_q >= CW'(2)) begin
            m_valid_d = 1'b1;
            win_row_d = row_q - ROW_BIT'(2);
            win_col_d = col_q - CW'(2);
          end
          if (col_end) begin
            col_d = '0;
            row_d = row_q + ROW_BIT'(1);
            if (row_end) last_d = 1'b1;
          end else begin
            col_d = col_q + CW'(1);
          end
          if (almost_full[0]) err_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (drained) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      prime_q   <= '0;
      last_q    <= 1'b0;
      m_valid_q <= 1'b0;
      win_row_q <= '0;
      win_col_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      col_q     <= col_d;
      row_q     <= row_d;
      prime_q   <= prime_d;
      last_q    <= last_d;
      m_valid_q <= m_valid_d;
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
      err_q     <= err_d;
    end
  end

  assign depth   = w_q;
  assign m_valid = m_valid_q;
  assign win_row = win_row_q;
  assign win_col = win_col_q;
  assign err     = err_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Bench for line_buffer_ctrl: frame-level model checked every cycle plus directed literals.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: m_ready stalls and s_valid gaps are driven from the frame task.
module tb_line_buffer_ctrl;

  localparam int AB = 3;
  localparam int RB = 8;
  localparam int MAXW = 1 << AB;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AB:0]   width = '0;
  logic [RB-1:0] height = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [2:0]    empty;
  logic [2:0]    almost_full = 3'b000;
  logic          wen, ren;
  logic [AB:0]   depth;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [RB-1:0] win_row;
  logic [AB:0]   win_col;
  logic          busy, done, err;

  int tests = 0;
  int fails = 0;

  line_buffer_ctrl #(.ADDR_BIT(AB), .ROW_BIT(RB)) dut (
    .clk(clk), .rst(rst), .start(start), .width(width), .height(height),
    .s_valid(s_valid), .s_ready(s_ready), .empty(empty), .almost_full(almost_full),
    .wen(wen), .ren(ren), .depth(depth), .m_valid(m_valid), .m_ready(m_ready),
    .win_row(win_row), .win_col(win_col), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Line-buffer occupancy stand-in: empty flags fall once anything is stored.
  int occ = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) occ <= 0;
    else     occ <= occ + int'(wen) - int'(ren);
  end
  assign empty = (occ == 0) ? 3'b111 : 3'b000;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: mode 0 idle, 1 intake, 2 drain.
  int mode = 0, mw = 0, mh = 0, n_acc = 0, k = 0, exp_depth = 0;
  bit exp_mv = 0, exp_err = 0;
  int wen_cnt = 0, ren_cnt = 0, win_cnt = 0, done_cnt = 0, first_ren = -1;

  always @(negedge clk) begin
    bit run, fl, drained, exp_rdy, acc_m;
    if (rst) begin
      chk("rst_outs", {s_ready, wen, ren, m_valid, busy, done, err}, 0);
      chk("rst_vals", {depth, win_row, win_col}, 0);
      mode = 0; exp_mv = 0; exp_err = 0; exp_depth = 0; n_acc = 0; k = 0;
    end else begin
      run     = (mode == 1);
      fl      = (mode == 2);
      drained = (empty == 3'b111);
      exp_rdy = run && !(exp_mv && !m_ready) && (n_acc < mw * mh);
      acc_m   = exp_rdy && s_valid;
      chk("s_ready", s_ready, exp_rdy);
      chk("wen", wen, acc_m);
      chk("ren", ren, run ? (acc_m && n_acc >= 2 * mw + 2) : (fl && !drained));
      chk("m_valid", m_valid, exp_mv);
      if (exp_mv) begin
        chk("win_row", win_row, k / (mw - 2));
        chk("win_col", win_col, k % (mw - 2));
      end
      chk("busy", busy, run || (fl && !drained));
      chk("done", done, fl && drained);
      chk("err", err, exp_err);
      chk("depth", depth, exp_depth);
      if (wen) begin
        if (ren && first_ren < 0) first_ren = wen_cnt;
        wen_cnt++;
      end
      if (ren) ren_cnt++;
      if (m_valid && m_ready) win_cnt++;
      if (done) done_cnt++;
      case (mode)
        0: if (start) begin
          if (width >= 3 && width <= MAXW && height >= 3) begin
            mode = 1; mw = int'(width); mh = int'(height);
            n_acc = 0; k = 0; exp_mv = 0; exp_err = 0; exp_depth = mw;
            wen_cnt = 0; ren_cnt = 0; win_cnt = 0; done_cnt = 0; first_ren = -1;
          end else begin
            exp_err = 1;
          end
        end
        1: begin
          if (exp_mv && m_ready) begin
            exp_mv = 0;
            k++;
            if (n_acc == mw * mh) mode = 2;
          end
          if (acc_m) begin
            if (n_acc / mw >= 2 && n_acc % mw >= 2) exp_mv = 1;
            if (almost_full[0]) exp_err = 1;
            n_acc++;
          end
        end
        2: if (drained) mode = 0;
        default: mode = 0;
      endcase
    end
  end

  task automatic run_frame(input int w, input int h, input int stall, input int af_cyc,
                           input bit gaps, input int exp_wins);
    int cyc;
    int stall_left;
    @(posedge clk); #1;
    width = (AB+1)'(w); height = RB'(h); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; m_ready = 1'b1; s_valid = 1'b1;
    cyc = 0;
    stall_left = stall;
    while (done_cnt == 0 && cyc < 1000) begin
      s_valid     = gaps ? (cyc % 3 != 1) : 1'b1;
      start       = (cyc == 3);
      width       = (cyc == 3) ? 4'd7 : (AB+1)'(w);
      almost_full = (cyc == af_cyc) ? 3'b001 : 3'b000;
      if (stall_left > 0 && m_valid) begin
        m_ready = 1'b0;
        stall_left--;
      end else begin
        m_ready = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    s_valid = 1'b0; start = 1'b0; almost_full = 3'b000; m_ready = 1'b1;
    chk("frame_done_reached", int'(done_cnt > 0), 1);
    repeat (2) @(posedge clk);
    #1;
    chk("done_once", done_cnt, 1);
    chk("frame_windows", win_cnt, exp_wins);
    chk("frame_writes", wen_cnt, w * h);
    chk("idle_busy", busy, 0);
  endtask

  task automatic bad_start(input int w, input int h);
    @(posedge clk); #1;
    width = (AB+1)'(w); height = RB'(h); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("bad_start_err", err, 1);
    chk("bad_start_busy", busy, 0);
    @(posedge clk); #1;
    chk("bad_start_stay_idle", busy, 0);
  endtask

  initial begin
    int cyc;
    #1 rst = 1'b1;
    #2;
    chk("reset_s_ready", s_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_depth", depth, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 4x4 continuous: first shift on pixel 10, 16 reads in total.
    run_frame(4, 4, 0, -1, 1'b0, 4);
    chk("w4_first_ren", first_ren, 10);
    chk("w4_ren_total", ren_cnt, 16);

    // Minimum 3x3 frame.
    run_frame(3, 3, 0, -1, 1'b0, 1);
    chk("w3_ren_total", ren_cnt, 9);

    // 4x5 with the first window held for 3 cycles.
    run_frame(4, 5, 3, -1, 1'b0, 6);

    // Out-of-range starts, then a valid gapped frame clears err.
    bad_start(2, 4);
    bad_start(9, 4);
    bad_start(4, 2);
    run_frame(5, 4, 0, -1, 1'b1, 6);
    chk("err_cleared", err, 0);

    // Reset after 7 accepted pixels.
    @(posedge clk); #1;
    width = 4'd4; height = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
    cyc = 0;
    while (wen_cnt < 7 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("seven_pixels", wen_cnt, 7);
    rst = 1'b1;
    #1;
    chk("midrst_outs", {s_ready, wen, ren, m_valid, busy, done, err}, 0);
    chk("midrst_depth", depth, 0);
    chk("midrst_win", {win_row, win_col}, 0);
    @(posedge clk); #1;
    rst = 1'b0; s_valid = 1'b0;
    run_frame(4, 4, 0, -1, 1'b0, 4);

    // Overflow during a write: sticky through done.
    run_frame(6, 3, 0, 5, 1'b0, 4);
    chk("af_err_sticky", err, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d fails=%0d", tests, fails);
    $fatal(1);
  end

endmodule
